// File: rtl/replica_pkg.sv
// replica_pkg: shared types and constants for the replica-exchange blocks.
//   total_data_t        per-replica total distance (unsigned)
//   exchange_command_t  per-replica swap command (NOP / SELF / PREV / FOLW)
//   exchange_state_t    exchange controller FSM states
//   DBETA_Q16           inverse-temperature step between adjacent replicas, unsigned Q16
//   exp_lut_val()       elaboration-time generator for the exp(-y/64) ROM contents
package replica_pkg;

    localparam int TD_W = 32;
    typedef logic [TD_W-1:0] total_data_t;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        SELF = 2'd1,
        PREV = 2'd2,
        FOLW = 2'd3
    } exchange_command_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        WAIT,
        ISSUE
    } exchange_state_t;

    localparam logic [31:0] DBETA_Q16     = 32'h0001_0000;
    localparam int          EXP_LUT_DEPTH = 1024;
    localparam int          Y_W           = $clog2(EXP_LUT_DEPTH);
    localparam int          Y_SHIFT       = 27;
    localparam int          DE_W          = TD_W + 1;
    localparam int          PROD_W        = 2 * DE_W;

    // floor(exp(-y/64) * 2^32), clamped to 32 bits. Integer-only so it folds
    // at elaboration: e^(1/64) by Taylor series in Q64, raised to y by
    // square-and-multiply, then inverted.
    function automatic logic [31:0] exp_lut_val(input int unsigned y);
        logic [191:0] e1, term, p, b, q;
        int unsigned  n;
        term = 192'(1) << 64;
        e1   = '0;
        for (int k = 1; k <= 24; k++) begin
            e1   = e1 + term;
            term = term / 192'(64 * k);
        end
        p = 192'(1) << 64;
        b = e1;
        n = y;
        for (int i = 0; i < 10; i++) begin
            if (n[0]) p = (p * b) >> 64;
            b = (b * b) >> 64;
            n = n >> 1;
        end
        q = (192'(1) << 96) / p;
        exp_lut_val = (q > 192'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

endpackage

// File: rtl/exchange_exp_lut.sv
// exchange_exp_lut: 1024 x 32 ROM of floor(exp(-y/64) * 2^32) with a
// registered read; it forms the second stage of the acceptance pipeline.
//   clk   in   clock
//   addr  in   y, exponent in units of 1/64 (0..1023)
//   data  out  L for the address presented on the previous cycle
module exchange_exp_lut
    import replica_pkg::*;
(
    input  logic           clk,
    input  logic [Y_W-1:0] addr,
    output logic [31:0]    data
);

    logic [31:0] rom [EXP_LUT_DEPTH];

    for (genvar i = 0; i < EXP_LUT_DEPTH; i++) begin : g_rom
        localparam logic [31:0] VAL = exp_lut_val(i);
        assign rom[i] = VAL;
    end

    always_ff @(posedge clk) begin
        data <= rom[addr];
    end

endmodule

// File: rtl/exchange_control.sv
// exchange_control: replica-exchange sweep controller. On start it snapshots
// all replica distances, tests adjacent pairs of the current phase through a
// 2-stage acceptance pipeline, and issues one cycle of PREV/FOLW commands.
//   clk, reset    clock, synchronous active-high reset
//   start         sweep request, sampled only in IDLE
//   total_data    per-replica total distance
//   r_exchange    uniform random, one value consumed per EVAL cycle
//   command       per-replica exchange command (NOP except during ISSUE)
//   busy          high while state != IDLE
//   done          one-cycle pulse during ISSUE
//   phase         pair parity for the next sweep
//   accept_count  per-pair saturating accept counters (EXCHANGE_STATS_EN only)
// Optional feature macro: EXCHANGE_STATS_EN.
module exchange_control
    import replica_pkg::*;
#(
    parameter  int N_REPLICA = 32,
    localparam int N_PAIR    = (N_REPLICA > 1) ? N_REPLICA - 1 : 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  total_data_t [N_REPLICA-1:0]         total_data,
    input  logic [31:0]                         r_exchange,
    output exchange_command_t [N_REPLICA-1:0]   command,
    output logic                                busy,
    output logic                                done,
    output logic                                phase
`ifdef EXCHANGE_STATS_EN
    ,
    output logic [N_PAIR-1:0][31:0]             accept_count
`endif
);

    exchange_state_t             state;
    total_data_t [N_REPLICA-1:0] snap;
    logic [6:0]                  k;
    logic                        wait_cnt;
    logic [N_PAIR-1:0]           accept, acc_nxt;
    exchange_command_t [N_REPLICA-1:0] cmd_nxt;

    // pipeline: [1] dE registered, [2] LUT output valid
    logic [2:1]                  vld_pipe;
    logic signed [DE_W-1:0]      de, s1_de;
    logic [31:0]                 s1_r, s2_r;
    logic [6:0]                  s1_k, s2_k;
    logic                        s2_le0, s2_sat, s2_acc;
    total_data_t                 e_lo, e_hi;
    logic signed [PROD_W-1:0]    prod, y_full;
    logic                        sat;
    logic [Y_W-1:0]              y_addr;
    logic [31:0]                 lut_q;

    always_comb begin
        e_lo = '0;
        e_hi = '0;
        for (int i = 0; i < N_REPLICA - 1; i++) begin
            if (int'(k) == i) begin
                e_lo = snap[i];
                e_hi = snap[i+1];
            end
        end
    end

    assign de     = $signed({1'b0, e_lo}) - $signed({1'b0, e_hi});
    assign prod   = PROD_W'(s1_de) * PROD_W'($signed({1'b0, DBETA_Q16}));
    assign y_full = prod >>> Y_SHIFT;
    assign sat    = (y_full >= PROD_W'(1023));
    // negative y only arises for dE < 0, which accepts regardless of L
    assign y_addr = sat ? Y_W'(1023) : (y_full[PROD_W-1] ? '0 : y_full[Y_W-1:0]);

    exchange_exp_lut u_lut (
        .clk  (clk),
        .addr (y_addr),
        .data (lut_q)
    );

    assign s2_acc = s2_le0 || (!s2_sat && (s2_r < lut_q));

    // Fold the stage-2 decision in combinationally so the last pair's result
    // is available when command is registered on entry to ISSUE.
    always_comb begin
        acc_nxt = accept;
        for (int i = 0; i < N_REPLICA - 1; i++) begin
            if (vld_pipe[2] && int'(s2_k) == i) acc_nxt[i] = s2_acc;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REPLICA; i++) cmd_nxt[i] = NOP;
        for (int i = 0; i < N_REPLICA - 1; i++) begin
            if (acc_nxt[i]) begin
                cmd_nxt[i]   = FOLW;
                cmd_nxt[i+1] = PREV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < N_REPLICA; i++) command[i] <= NOP;
            snap     <= '0;
            accept   <= '0;
            k        <= '0;
            wait_cnt <= 1'b0;
            vld_pipe <= '0;
            s1_de    <= '0;
            s1_r     <= '0;
            s1_k     <= '0;
            s2_r     <= '0;
            s2_k     <= '0;
            s2_le0   <= 1'b0;
            s2_sat   <= 1'b0;
        end else begin
            vld_pipe[1] <= (state == EVAL);
            vld_pipe[2] <= vld_pipe[1];
            s1_de  <= de;
            s1_r   <= r_exchange;
            s1_k   <= k;
            s2_r   <= s1_r;
            s2_k   <= s1_k;
            s2_le0 <= s1_de[DE_W-1] || (s1_de == '0);
            s2_sat <= sat;
            accept <= acc_nxt;
            done   <= 1'b0;
            for (int i = 0; i < N_REPLICA; i++) command[i] <= NOP;

            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= total_data;
                        k        <= {6'd0, phase};
                        accept   <= '0;
                        busy     <= 1'b1;
                        wait_cnt <= 1'b0;
                        state    <= (int'(phase) + 1 < N_REPLICA) ? EVAL : WAIT;
                    end
                end
                EVAL: begin
                    if (int'(k) + 3 >= N_REPLICA) state <= WAIT;
                    else                          k     <= k + 7'd2;
                end
                WAIT: begin
                    if (wait_cnt) begin
                        state   <= ISSUE;
                        command <= cmd_nxt;
                        done    <= 1'b1;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    phase <= ~phase;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EXCHANGE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            accept_count <= '0;
        end else if (state == ISSUE) begin
            for (int i = 0; i < N_REPLICA - 1; i++) begin
                if (accept[i] && accept_count[i] != 32'hFFFF_FFFF)
                    accept_count[i] <= accept_count[i] + 32'd1;
            end
        end
    end
`endif

endmodule
